// File: rtl/bnn_layer_sched_if.sv
// Pixel stream bundle: upstream image source -> frame scheduler -> datapath input.
// The scheduler uses the slave modport; the source/sink environment uses master.
interface bnn_layer_sched_if;
  logic               pix_in_valid;
  logic signed [31:0] pix_in_data;
  logic               pix_in_ready;
  logic               pix_out_valid;
  logic signed [31:0] pix_out_data;
  logic               pix_out_ready;

  modport slave (
    input  pix_in_valid, pix_in_data, pix_out_ready,
    output pix_in_ready, pix_out_valid, pix_out_data
  );

  modport master (
    output pix_in_valid, pix_in_data, pix_out_ready,
    input  pix_in_ready, pix_out_valid, pix_out_data
  );
endinterface

// File: rtl/bnn_layer_sched.sv
// Frame scheduler: streams one image to the datapath, then runs each layer engine in turn.
// Optional per-layer watchdog compiled in with `define SCHED_WATCHDOG_EN.
module bnn_layer_sched #(
  parameter int unsigned N_LAYERS  = 4,
  parameter int unsigned PIX_COUNT = 784,
  parameter int unsigned NCLS      = 10,
  parameter int unsigned TIMEOUT   = 65535,
  localparam int unsigned IdxW     = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                frame_start,
  input  logic                abort,
  bnn_layer_sched_if.slave    pix,
  output logic [N_LAYERS-1:0] layer_start,
  input  logic [N_LAYERS-1:0] layer_done,
  output logic [IdxW-1:0]     layer_idx,
  output logic                buf_sel,
  output logic                busy,
  output logic                frame_done,
  input  logic [NCLS-1:0]     class_in,
  output logic [NCLS-1:0]     class_out,
  output logic                err,
  output logic [15:0]         frame_cnt
);

`ifdef SCHED_WATCHDOG_EN
  typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StDone} state_e;
`endif

  state_e      state_q;
  logic [31:0] pix_cnt_q;
  logic        beat;
  logic        last_layer;
`ifdef SCHED_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
`endif

  // Pixel path is a pure wire through the scheduler, gated to LOAD only.
  always_comb begin
    pix.pix_in_ready  = 1'b0;
    pix.pix_out_valid = 1'b0;
    pix.pix_out_data  = '0;
    if (state_q == StLoad) begin
      pix.pix_in_ready  = pix.pix_out_ready;
      pix.pix_out_valid = pix.pix_in_valid;
      pix.pix_out_data  = pix.pix_in_data;
    end
  end

  always_comb begin
    beat       = (state_q == StLoad) && pix.pix_in_valid && pix.pix_out_ready;
    last_layer = (layer_idx == IdxW'(N_LAYERS - 1));
    busy       = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      layer_start <= '0;
      layer_idx   <= '0;
      buf_sel     <= 1'b0;
      frame_done  <= 1'b0;
      class_out   <= '0;
      frame_cnt   <= '0;
`ifdef SCHED_WATCHDOG_EN
      wd_cnt_q    <= '0;
      err         <= 1'b0;
`endif
    end else begin
      layer_start <= '0;
      frame_done  <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
`ifdef SCHED_WATCHDOG_EN
        err     <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (frame_start) begin
              state_q   <= StLoad;
              pix_cnt_q <= '0;
              layer_idx <= '0;
              buf_sel   <= 1'b0;
            end
          end
          StLoad: begin
            if (beat) begin
              pix_cnt_q <= pix_cnt_q + 32'd1;
              if (pix_cnt_q == PIX_COUNT - 1) begin
                state_q                <= StRun;
                layer_start[layer_idx] <= 1'b1;
              end
            end
          end
          StRun: begin
            state_q  <= StWait;
`ifdef SCHED_WATCHDOG_EN
            wd_cnt_q <= '0;
`endif
          end
          StWait: begin
            // Only the running layer's done bit matters; strays are dropped.
            if (layer_done[layer_idx]) begin
              if (last_layer) begin
                state_q    <= StDone;
                frame_done <= 1'b1;
                class_out  <= class_in;
                frame_cnt  <= frame_cnt + 16'd1;
              end else begin
                state_q                             <= StRun;
                layer_idx                           <= layer_idx + IdxW'(1);
                buf_sel                             <= ~buf_sel;
                layer_start[layer_idx + IdxW'(1)]   <= 1'b1;
              end
            end
`ifdef SCHED_WATCHDOG_EN
            else if (wd_cnt_q == TIMEOUT - 1) begin
              state_q <= StErr;
              err     <= 1'b1;
            end else begin
              wd_cnt_q <= wd_cnt_q + 32'd1;
            end
`endif
          end
          StDone: state_q <= StIdle;
`ifdef SCHED_WATCHDOG_EN
          StErr:  state_q <= StErr;
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifndef SCHED_WATCHDOG_EN
  assign err = 1'b0;
`endif

endmodule
